// File: rtl/clock_gen_ctrl_if.sv
// Configuration write port of the divided-clock bank controller: a valid/ready
// handshake that carries a channel index, a divide value and an enable.
interface clock_gen_ctrl_if #(
   parameter int clock_number = 8,
   parameter int DIV_WIDTH    = 8
);
   logic                            cfg_valid;
   logic                            cfg_ready;
   logic [$clog2(clock_number)-1:0] cfg_chan;
   logic [DIV_WIDTH-1:0]            cfg_div;
   logic                            cfg_en;

   modport master (
      output cfg_valid, cfg_chan, cfg_div, cfg_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_div, cfg_en,
      output cfg_ready
   );
endinterface

// File: rtl/clock_gen_ctrl.sv
// Divided-clock bank controller: per-channel divide/enable updates committed glitch-free
// at the falling edge of each divided clock. Define CLOCK_GEN_CTRL_DONE_EN for cfg_done outputs.
module clock_gen_ctrl #(
   parameter int clock_number = 8,
   parameter int DIV_WIDTH    = 8
) (
   input  logic                            mainclock,
   input  logic                            resetn,
   clock_gen_ctrl_if.slave                 cfg,
   output logic [clock_number-1:0]         out_clocks,
   output logic [clock_number-1:0]         ticks,
   output logic [clock_number-1:0]         active_mask
`ifdef CLOCK_GEN_CTRL_DONE_EN
   ,
   output logic                            cfg_done,
   output logic [$clog2(clock_number)-1:0] cfg_done_chan
`endif
);

   localparam int CHAN_W = $clog2(clock_number);

   logic [DIV_WIDTH-1:0]    act_div  [clock_number];
   logic [DIV_WIDTH-1:0]    pend_div [clock_number];
   logic [DIV_WIDTH-1:0]    cnt      [clock_number];
   logic [clock_number-1:0] pend_en;
   logic [clock_number-1:0] pend_flag;
   logic [clock_number-1:0] wr_sel;
   logic [clock_number-1:0] commit;

   // Channel indices with no matching channel fall through with ready high and no select,
   // so out-of-range writes complete and vanish.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      cfg.cfg_ready = 1'b1;
      wr_sel        = '0;
      for (int j = 0; j < clock_number; j++) begin
         if (cfg.cfg_chan == CHAN_W'(j)) begin
            cfg.cfg_ready = !pend_flag[j];
            wr_sel[j]     = cfg.cfg_valid && !pend_flag[j];
         end
      end
   end

   // A commit lands either on an idle channel or on the tick that ends the high phase.
   always_comb begin
      ticks  = '0;
      commit = '0;
      for (int j = 0; j < clock_number; j++) begin
         ticks[j]  = active_mask[j] && (cnt[j] == '0);
         commit[j] = pend_flag[j] && (!active_mask[j] || ((cnt[j] == '0) && out_clocks[j]));
      end
   end

   always_ff @(posedge mainclock or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the per-channel arrays are control state, not storage, so they are reset too.
         for (int j = 0; j < clock_number; j++) begin
            act_div[j]  <= '0;
            pend_div[j] <= '0;
            cnt[j]      <= '0;
         end
         pend_en     <= '0;
         pend_flag   <= '0;
         active_mask <= '0;
         out_clocks  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every channel reading pre-edge state.
         for (int j = 0; j < clock_number; j++) begin
            if (wr_sel[j]) begin
               pend_div[j]  <= cfg.cfg_div;
               pend_en[j]   <= cfg.cfg_en;
               pend_flag[j] <= 1'b1;
            end

            if (commit[j]) begin
               act_div[j]     <= pend_div[j];
               active_mask[j] <= pend_en[j];
               pend_flag[j]   <= 1'b0;
               cnt[j]         <= pend_en[j] ? pend_div[j] : '0;
               out_clocks[j]  <= 1'b0;
            end else if (!active_mask[j]) begin
               cnt[j]        <= '0;
               out_clocks[j] <= 1'b0;
            end else if (ticks[j]) begin
               cnt[j]        <= act_div[j];
               out_clocks[j] <= !out_clocks[j];
            end else begin
               cnt[j] <= cnt[j] - DIV_WIDTH'(1);
            end
         end
      end
   end

`ifdef CLOCK_GEN_CTRL_DONE_EN
   logic [CHAN_W-1:0] low_chan;

   // Scan downwards so the lowest committed channel is the last one written.
   always_comb begin
      low_chan = '0;
      for (int j = clock_number - 1; j >= 0; j--) begin
         if (commit[j]) low_chan = CHAN_W'(j);
      end
   end

   always_ff @(posedge mainclock or negedge resetn) begin
      if (!resetn) begin
         cfg_done      <= 1'b0;
         cfg_done_chan <= '0;
      end else begin
         cfg_done <= |commit;
         if (|commit) cfg_done_chan <= low_chan;
      end
   end
`endif

endmodule

// File: tb/tb_clock_gen_ctrl.sv
// Self-checking bench for clock_gen_ctrl: an arithmetic per-channel model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_clock_gen_ctrl;
   localparam int N  = 6;
   localparam int DW = 8;
   localparam int CW = $clog2(N);

   logic          mainclock = 1'b0;
   logic          resetn;
   logic [N-1:0]  out_clocks;
   logic [N-1:0]  ticks;
   logic [N-1:0]  active_mask;
`ifdef CLOCK_GEN_CTRL_DONE_EN
   logic          cfg_done;
   logic [CW-1:0] cfg_done_chan;
`endif

   clock_gen_ctrl_if #(.clock_number(N), .DIV_WIDTH(DW)) cfg ();

   clock_gen_ctrl #(.clock_number(N), .DIV_WIDTH(DW)) dut (
      .mainclock   (mainclock),
      .resetn      (resetn),
      .cfg         (cfg),
      .out_clocks  (out_clocks),
      .ticks       (ticks),
      .active_mask (active_mask)
`ifdef CLOCK_GEN_CTRL_DONE_EN
      ,
      .cfg_done      (cfg_done),
      .cfg_done_chan (cfg_done_chan)
`endif
   );

   always #5 mainclock = ~mainclock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: an enabled channel is described only by its divide value and the cycle of its
   // commit; tick and level follow from elapsed cycles since that commit.
   bit m_en   [N];
   bit m_pend [N];
   bit m_pen  [N];
   int m_div  [N];
   int m_pdiv [N];
   int m_c    [N];
   int cyc = 0;
   bit m_done = 1'b0;
   int m_done_chan = 0;

   function automatic bit e_tick(input int j);
      int k;
      if (!m_en[j]) return 1'b0;
      k = cyc - m_c[j] - 1;
      return ((k + 1) % (m_div[j] + 1)) == 0;
   endfunction

   function automatic bit e_out(input int j);
      int k;
      if (!m_en[j]) return 1'b0;
      k = cyc - m_c[j] - 1;
      return ((k / (m_div[j] + 1)) % 2) == 1;
   endfunction

   initial begin : compare
      logic [N-1:0] et;
      logic [N-1:0] eo;
      logic [N-1:0] em;
      bit           er;
      bit           any;
      int           dch;
      forever begin
         @(negedge mainclock);
         if (!resetn) begin
            for (int j = 0; j < N; j++) begin
               m_en[j] = 1'b0; m_pend[j] = 1'b0; m_pen[j] = 1'b0;
               m_div[j] = 0; m_pdiv[j] = 0; m_c[j] = 0;
            end
            m_done = 1'b0;
            m_done_chan = 0;
            check("rst_out_clocks", 64'(out_clocks), 64'(0));
            check("rst_ticks", 64'(ticks), 64'(0));
            check("rst_active_mask", 64'(active_mask), 64'(0));
         end else begin
            for (int j = 0; j < N; j++) begin
               et[j] = e_tick(j);
               eo[j] = e_out(j);
               em[j] = m_en[j];
            end
            er = 1'b1;
            if (int'(cfg.cfg_chan) < N) er = !m_pend[int'(cfg.cfg_chan)];
            check("model_ticks", 64'(ticks), 64'(et));
            check("model_out_clocks", 64'(out_clocks), 64'(eo));
            check("model_active_mask", 64'(active_mask), 64'(em));
            check("model_cfg_ready", 64'(cfg.cfg_ready), 64'(er));
`ifdef CLOCK_GEN_CTRL_DONE_EN
            check("model_cfg_done", 64'(cfg_done), 64'(m_done));
            check("model_cfg_done_chan", 64'(cfg_done_chan), 64'(m_done_chan));
`endif
            any = 1'b0;
            dch = 0;
            for (int j = 0; j < N; j++) begin
               if (m_pend[j] && (!m_en[j] || (et[j] && eo[j]))) begin
                  m_en[j]   = m_pen[j];
                  m_div[j]  = m_pdiv[j];
                  m_c[j]    = cyc;
                  m_pend[j] = 1'b0;
                  if (!any) dch = j;
                  any = 1'b1;
               end else if (cfg.cfg_valid && er && int'(cfg.cfg_chan) == j) begin
                  m_pend[j] = 1'b1;
                  m_pdiv[j] = int'(cfg.cfg_div);
                  m_pen[j]  = cfg.cfg_en;
               end
            end
            m_done = any;
            if (any) m_done_chan = dch;
         end
         cyc++;
      end
   end

   task automatic write(input int ch, input int d, input bit en);
      int n = 0;
      @(posedge mainclock); #1;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_chan  = CW'(ch);
      cfg.cfg_div   = DW'(d);
      cfg.cfg_en    = en;
      @(negedge mainclock);
      while (!cfg.cfg_ready && n < 300) begin
         @(negedge mainclock);
         n++;
      end
      check("write_accept", 64'(n < 300), 64'(1));
      @(posedge mainclock); #1;
      cfg.cfg_valid = 1'b0;
   endtask

   task automatic wait_out(input int j, input bit lvl);
      int n = 0;
      while (out_clocks[j] !== lvl && n < 300) begin
         @(negedge mainclock);
         n++;
      end
      check("wait_out", 64'(n < 300), 64'(1));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      resetn        = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_chan  = '0;
      cfg.cfg_div   = '0;
      cfg.cfg_en    = 1'b0;
      repeat (3) @(posedge mainclock);
      @(negedge mainclock);
      check("reset_out_clocks", 64'(out_clocks), 64'(0));
      check("reset_ticks", 64'(ticks), 64'(0));
      check("reset_active_mask", 64'(active_mask), 64'(0));
      check("reset_cfg_ready", 64'(cfg.cfg_ready), 64'(1));
      @(posedge mainclock); #3;
      resetn = 1'b1;

      // ch0 D=3 from idle: accepted at the end of cycle 0, numbered from there.
      write(0, 3, 1);
      for (int i = 1; i <= 13; i++) begin
         @(negedge mainclock);
         check("t1_tick0", 64'(ticks[0]), 64'(i == 5 || i == 9 || i == 13));
         check("t1_out0", 64'(out_clocks[0]), 64'(i >= 6 && i <= 9));
         check("t1_mask", 64'(active_mask), 64'(i >= 2 ? 1 : 0));
         if (i == 1) check("t1_ready_pending", 64'(cfg.cfg_ready), 64'(0));
         if (i == 2) check("t1_ready_free", 64'(cfg.cfg_ready), 64'(1));
      end

      // Retarget ch0 to D=1 during its high phase: commit at the falling edge, then period 4.
      wait_out(0, 1'b1);
      write(0, 1, 1);
      @(negedge mainclock);
      check("t2_ready_pending", 64'(cfg.cfg_ready), 64'(0));
      n = 0;
      while (!cfg.cfg_ready && n < 40) begin
         @(negedge mainclock);
         n++;
      end
      check("t2_commit_seen", 64'(n < 40), 64'(1));
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge mainclock);
         check("t2_out0", 64'(out_clocks[0]), 64'((i / 2) % 2));
         check("t2_tick0", 64'(ticks[0]), 64'(i % 2));
      end

      // ch2 started then disabled while running.
      write(2, 2, 1);
      repeat (7) @(negedge mainclock);
      write(2, 2, 0);
      repeat (20) @(negedge mainclock);
      check("t3_out2", 64'(out_clocks[2]), 64'(0));
      check("t3_tick2", 64'(ticks[2]), 64'(0));
      check("t3_mask2", 64'(active_mask[2]), 64'(0));

      // ch1 D=0: tick every cycle, level toggles every cycle.
      write(1, 0, 1);
      @(posedge mainclock); #1;
      for (int i = 0; i < 6; i++) begin
         @(negedge mainclock);
         check("t4_tick1", 64'(ticks[1]), 64'(1));
         check("t4_out1", 64'(out_clocks[1]), 64'(i % 2));
      end

      // Out-of-range channel: accepted and dropped.
      write(N, 5, 1);
      @(negedge mainclock);
      check("t5_ready", 64'(cfg.cfg_ready), 64'(1));
      check("t5_mask", 64'(active_mask), 64'(6'b000011));
      repeat (10) @(negedge mainclock);
      check("t5_mask_later", 64'(active_mask), 64'(6'b000011));

      // Reset with writes pending on ch0 and ch3.
      write(0, 60, 1);
      write(3, 60, 1);
      write(0, 2, 1);
      write(3, 2, 1);
      @(negedge mainclock);
      check("t6_ready_pending3", 64'(cfg.cfg_ready), 64'(0));
      @(posedge mainclock); #3;
      resetn = 1'b0;
      #1;
      check("t6_async_out_clocks", 64'(out_clocks), 64'(0));
      check("t6_async_ticks", 64'(ticks), 64'(0));
      check("t6_async_mask", 64'(active_mask), 64'(0));
      check("t6_async_ready", 64'(cfg.cfg_ready), 64'(1));
`ifdef CLOCK_GEN_CTRL_DONE_EN
      check("t6_async_done", 64'(cfg_done), 64'(0));
`endif
      repeat (3) @(posedge mainclock);
      #3;
      resetn = 1'b1;
      repeat (150) @(negedge mainclock);
      check("t6_no_commit_mask", 64'(active_mask), 64'(0));
      check("t6_no_commit_out", 64'(out_clocks), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_gen_ctrl.md
# clock_gen_ctrl

Runtime-programmable controller for the divided-clock bank. Owns one down-counter per output channel and accepts per-channel divide/enable writes over a valid/ready port. Every update is applied glitch-free at a period boundary. Drives the divided clocks (`out_clocks`) plus a one-cycle clock-enable pulse per channel (`ticks`) for logic that stays on `mainclock`.

## Interface
- `clock_number`, default 8: number of output channels (≥2).
- `DIV_WIDTH`, default 8: width of the divide value.
- `mainclock`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  write can be accepted this cycle.
- `cfg_chan`  in  $clog2(clock_number)  target channel.
- `cfg_div`  in  DIV_WIDTH  divide value D.
- `cfg_en`  in  1  channel enable.
- `out_clocks`  out  clock_number  divided clocks, registered, period 2·(D+1).
- `ticks`  out  clock_number  one-cycle enable pulse, period D+1.
- `active_mask`  out  clock_number  committed enable per channel.

## Operation
- Per channel j, state is:
  - active D and enable;
  - pending D and enable, with a pending flag;
  - counter (DIV_WIDTH bits);
  - out bit.
- Handshake:
  - `cfg_ready` = !pending[cfg_chan]; a transfer occurs when `cfg_valid && cfg_ready`.
  - On transfer, the pending regs for `cfg_chan` load `cfg_div`/`cfg_en` and the pending flag sets.
  - Out-of-range `cfg_chan` (≥ clock_number): `cfg_ready`=1, write accepted and discarded.
- Counting, for an enabled channel:
  - `ticks[j]` = (counter==0).
  - On tick: counter reloads active D and out toggles.
  - Otherwise: counter decrements.
  - D=0 means a tick every cycle, and out toggles every cycle.
- Disabled channel: counter held 0, tick 0, out held 0.
- Commit condition: pending=1 AND (active enable=0 OR (counter==0 AND out==1)), i.e. only at the falling edge of `out_clocks[j]`. On the commit edge:
  - active regs load pending;
  - pending clears;
  - counter loads new D;
  - out goes 0.
  - If the new enable is 0, the channel stays idle.
- Commit is independent per channel; several channels may commit on the same edge.
- Rewriting the same D/enable is legal and still goes through commit, which restarts the phase.

## Timing
- Reset values:
  - all active/pending regs 0, pending flags 0, counters 0;
  - `out_clocks`=0, `ticks`=0, `active_mask`=0, `cfg_ready`=1.
- Write accepted at edge N: pending visible in cycle N+1.
  - Disabled channel: commit at the end of N+1; first tick D cycles later; `out_clocks[j]` rises on the edge after that tick.
- Enabled channel: commit waits for the next tick with out==1, at most 2·(D_old+1) cycles after the write.
- A write to a channel on the same cycle as its commit sees `cfg_ready`=0; it can be accepted the next cycle.
- `ticks` is a combinational decode of registered state; `out_clocks` and `active_mask` are registers.
- Reset asserted mid-operation: all outputs return to reset values immediately (async), and pending writes are lost.

## Configuration
- `CLOCK_GEN_CTRL_DONE_EN` defined:
  - adds ports `cfg_done` (out, 1) and `cfg_done_chan` (out, $clog2(clock_number));
  - `cfg_done` is a registered pulse one cycle after any commit edge;
  - `cfg_done_chan` is the lowest-index channel committed on that edge.
  - Both reset to 0.
- Macro undefined: neither port exists, and commit behaviour is unchanged.

## Test plan
- Reset, then write ch0 D=3 en=1 at cycle 0:
  - pending in cycle 1;
  - `ticks[0]` high in cycles 5, 9, 13, …;
  - `out_clocks[0]` high cycles 6–9, low 10–13;
  - `active_mask`=0x01.
- With ch0 running D=3, write ch0 D=1 mid-high phase:
  - `cfg_ready` low for ch0 until commit;
  - commit only at the tick where out==1;
  - afterwards period 4 cycles, no runt pulse.
- Write ch2 en=0 while running: ch2 stops low after finishing its high phase, and `active_mask[2]` clears on the same edge.
- D=0 on ch1: `ticks[1]` constantly high and `out_clocks[1]` toggles every cycle.
- Write cfg_chan=clock_number: `cfg_ready`=1, no state change on any channel.
- Assert `resetn` low mid-run with pending writes on ch0/ch3:
  - all outputs 0 asynchronously;
  - after release no commit occurs;
  - with `CLOCK_GEN_CTRL_DONE_EN`, `cfg_done` stays 0.
